// File: rtl/integration_phase3_pkg.sv
// rtl/integration_phase3_pkg.sv - shared ALU opcode and operand-select encodings
package integration_phase3_pkg;

   localparam int WIDTH = 16;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_NOR = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRL = 3'b111
   } alu_op_t;

   typedef enum logic [3:0] {
      SEL_WR  = 4'd0,
      SEL_MEM = 4'd1,
      SEL_AR  = 4'd2,
      SEL_NA  = 4'd3,
      SEL_RV  = 4'd4,
      SEL_SP  = 4'd5,
      SEL_RA  = 4'd6,
      SEL_TP  = 4'd7,
      SEL_EXT = 4'd8,
      SEL_MA  = 4'd9
   } sel_t;

endpackage

// File: rtl/integration_phase3_if.sv
// rtl/integration_phase3_if.sv - operand sources, controls and registered ALU results
interface integration_phase3_if #(
   parameter int WIDTH = integration_phase3_pkg::WIDTH
);
   logic [WIDTH-1:0] wr;
   logic [WIDTH-1:0] Mem;
   logic [WIDTH-1:0] ar;
   logic [WIDTH-1:0] na;
   logic [WIDTH-1:0] rv;
   logic [WIDTH-1:0] sp;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] tp;
   logic [WIDTH-1:0] Ext;
   logic [WIDTH-1:0] ma;
   logic [WIDTH-1:0] Din;
   logic [3:0]       ALUInput1;
   logic [3:0]       ALUInput2;
   logic             Delta;
   logic [2:0]       ALUOp;
   logic [WIDTH-1:0] ALUOut;
   logic             zero;
   logic             overflow;
   logic             greaterThan;
   logic             lessThan;

   modport master (
      output wr, Mem, ar, na, rv, sp, ra, tp, Ext, ma, Din,
      output ALUInput1, ALUInput2, Delta, ALUOp,
      input  ALUOut, zero, overflow, greaterThan, lessThan
   );

   modport slave (
      input  wr, Mem, ar, na, rv, sp, ra, tp, Ext, ma, Din,
      input  ALUInput1, ALUInput2, Delta, ALUOp,
      output ALUOut, zero, overflow, greaterThan, lessThan
   );
endinterface

// File: rtl/integration_phase3_alu16.sv
// rtl/integration_phase3_alu16.sv - combinational ALU with signed compare of the operands
module integration_phase3_alu16
   import integration_phase3_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_t          op,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             gt,
   output logic             lt,
   output logic             zero
);

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (op)
         ALU_ADD: begin
            result   = a + b;
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            result   = a - b;
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_NOR: result = ~(a | b);
         ALU_SLL: result = a << b[3:0];
         ALU_SRL: result = a >> b[3:0];
         default: result = '0;
      endcase
   end

   // Compare flags look at the operands, not the result, so they hold for every opcode.
   assign gt   = $signed(a) > $signed(b);
   assign lt   = $signed(a) < $signed(b);
   assign zero = (result == '0);

endmodule

// File: rtl/integration_phase3.sv
// rtl/integration_phase3.sv - operand select muxes, Delta substitution and registered ALU stage
module integration_phase3
   import integration_phase3_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   integration_phase3_if.slave bus
);

   logic [WIDTH-1:0] src [16];
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_overflow;
   logic             alu_gt;
   logic             alu_lt;
   logic             alu_zero;

   // Unused select codes 10..15 keep their zero default.
   always_comb begin
      for (int i = 0; i < 16; i++) src[i] = '0;
      src[SEL_WR]  = bus.wr;
      src[SEL_MEM] = bus.Mem;
      src[SEL_AR]  = bus.ar;
      src[SEL_NA]  = bus.na;
      src[SEL_RV]  = bus.rv;
      src[SEL_SP]  = bus.sp;
      src[SEL_RA]  = bus.ra;
      src[SEL_TP]  = bus.tp;
      src[SEL_EXT] = bus.Ext;
      src[SEL_MA]  = bus.ma;
   end

   assign op_a = src[bus.ALUInput1];
   assign op_b = bus.Delta ? bus.Din : src[bus.ALUInput2];

   integration_phase3_alu16 #(.WIDTH(WIDTH)) u_alu (
      .a        (op_a),
      .b        (op_b),
      .op       (alu_op_t'(bus.ALUOp)),
      .result   (alu_result),
      .overflow (alu_overflow),
      .gt       (alu_gt),
      .lt       (alu_lt),
      .zero     (alu_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.ALUOut      <= '0;
         bus.zero        <= 1'b0;
         bus.overflow    <= 1'b0;
         bus.greaterThan <= 1'b0;
         bus.lessThan    <= 1'b0;
      end else begin
         bus.ALUOut      <= alu_result;
         bus.zero        <= alu_zero;
         bus.overflow    <= alu_overflow;
         bus.greaterThan <= alu_gt;
         bus.lessThan    <= alu_lt;
      end
   end

endmodule

// File: tb/tb_integration_phase3.sv
// tb/tb_integration_phase3.sv - randomized self-checking bench against an arithmetic reference model
module tb_integration_phase3;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   logic [15:0] srcv [10];
   logic [15:0] din;
   logic [15:0] exp_out;
   logic        exp_zero;
   logic        exp_ovf;
   logic        exp_gt;
   logic        exp_lt;

   integration_phase3_if bus ();

   integration_phase3 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [15:0] a, input logic [15:0] b, input int op,
                                 output logic [15:0] r, output logic z, output logic o,
                                 output logic g, output logic l);
      int sa;
      int sb;
      int full;
      int ua;
      int k;
      sa = int'($signed(a));
      sb = int'($signed(b));
      ua = int'(a);
      k  = int'(b[3:0]);
      o  = 1'b0;
      full = 0;
      case (op)
         0: begin full = sa + sb; o = (full > 32767) || (full < -32768); end
         1: begin full = sa - sb; o = (full > 32767) || (full < -32768); end
         2: full = int'(a & b);
         3: full = int'(a | b);
         4: full = int'(a ^ b);
         5: full = int'(~(a | b));
         6: full = (ua * (2 ** k)) % 65536;
         default: full = ua / (2 ** k);
      endcase
      r = full[15:0];
      z = (r == 16'h0000);
      g = sa > sb;
      l = sa < sb;
   endfunction

   task automatic apply(input int s1, input int s2, input bit d, input int op);
      logic [15:0] a;
      logic [15:0] b;
      bus.wr  = srcv[0]; bus.Mem = srcv[1]; bus.ar = srcv[2]; bus.na = srcv[3];
      bus.rv  = srcv[4]; bus.sp  = srcv[5]; bus.ra = srcv[6]; bus.tp = srcv[7];
      bus.Ext = srcv[8]; bus.ma  = srcv[9]; bus.Din = din;
      bus.ALUInput1 = 4'(s1);
      bus.ALUInput2 = 4'(s2);
      bus.Delta     = d;
      bus.ALUOp     = 3'(op);
      a = (s1 < 10) ? srcv[s1] : 16'h0000;
      b = d ? din : ((s2 < 10) ? srcv[s2] : 16'h0000);
      model(a, b, op, exp_out, exp_zero, exp_ovf, exp_gt, exp_lt);
   endtask

   task automatic check_all(input string tag);
      check({tag, ".out"}, 32'(bus.ALUOut), 32'(exp_out));
      check({tag, ".zero"}, 32'(bus.zero), 32'(exp_zero));
      check({tag, ".ovf"}, 32'(bus.overflow), 32'(exp_ovf));
      check({tag, ".gt"}, 32'(bus.greaterThan), 32'(exp_gt));
      check({tag, ".lt"}, 32'(bus.lessThan), 32'(exp_lt));
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".out"}, 32'(bus.ALUOut), 32'h0);
      check({tag, ".zero"}, 32'(bus.zero), 32'h0);
      check({tag, ".ovf"}, 32'(bus.overflow), 32'h0);
      check({tag, ".gt"}, 32'(bus.greaterThan), 32'h0);
      check({tag, ".lt"}, 32'(bus.lessThan), 32'h0);
   endtask

   task automatic run_op(input string tag, input int s1, input int s2, input bit d, input int op);
      apply(s1, s2, d, op);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic preload();
      for (int i = 0; i < 10; i++) srcv[i] = 16'(i);
      din = 16'd10;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      preload();
      apply(1, 2, 1'b0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      run_op("add", 1, 2, 1'b0, 0);
      check("add_const", 32'(bus.ALUOut), 32'd3);
      check("add_lt_const", 32'(bus.lessThan), 32'd1);
      run_op("sub", 7, 2, 1'b0, 1);
      check("sub_const", 32'(bus.ALUOut), 32'd5);
      run_op("sub_eq", 5, 5, 1'b0, 1);
      check("sub_eq_zero", 32'(bus.zero), 32'd1);
      run_op("and", 7, 2, 1'b0, 2);
      check("and_const", 32'(bus.ALUOut), 32'd2);
      run_op("or", 7, 2, 1'b0, 3);
      check("or_const", 32'(bus.ALUOut), 32'd7);
      run_op("delta", 0, 2, 1'b1, 0);
      check("delta_const", 32'(bus.ALUOut), 32'd10);
      run_op("bad_sel", 12, 2, 1'b1, 0);
      check("bad_sel_const", 32'(bus.ALUOut), 32'd10);
      run_op("bad_sel2", 3, 15, 1'b0, 3);

      srcv[0] = 16'h7FFF; din = 16'h0001;
      run_op("ovf_add", 0, 0, 1'b1, 0);
      check("ovf_add_const", 32'(bus.ALUOut), 32'h8000);
      check("ovf_add_flag", 32'(bus.overflow), 32'd1);
      srcv[1] = 16'h8000; srcv[2] = 16'h0001;
      run_op("ovf_sub", 1, 2, 1'b0, 1);
      check("ovf_sub_const", 32'(bus.ALUOut), 32'h7FFF);
      check("ovf_sub_flag", 32'(bus.overflow), 32'd1);
      srcv[3] = 16'hFFFF;
      run_op("wrap_zero", 3, 2, 1'b0, 0);
      check("wrap_zero_flag", 32'(bus.zero), 32'd1);
      srcv[4] = 16'h8001; srcv[5] = 16'h0013;
      run_op("sll", 4, 5, 1'b0, 6);
      run_op("srl", 4, 5, 1'b0, 7);

      // Reset mid-operation: pending result discarded, outputs held at 0 across an edge.
      preload();
      run_op("pre_reset", 7, 2, 1'b0, 0);
      apply(6, 3, 1'b0, 4);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("reset_async");
      @(posedge clk);
      #1;
      check_reset("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_all("reset_release");

      for (int it = 0; it < 400; it++) begin
         for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
               0: srcv[i] = 16'($urandom_range(0, 3));
               1: srcv[i] = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
               default: srcv[i] = 16'($urandom);
            endcase
         end
         din = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
         run_op("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
